// File: rtl/axi_overrange_poller_pkg.sv
// Shared types and constants for the ADC overrange status poller.
package axi_overrange_poller_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam int unsigned OVR_ADC1_BIT = 0;
  localparam int unsigned OVR_ADC2_BIT = 1;
  localparam int unsigned OVR_NUM      = 2;

endpackage

// File: rtl/axi_overrange_poller_sat_counter.sv
// Saturating event counter with synchronous clear; clear together with
// increment loads 1 so the coinciding event is not lost.
module axi_overrange_poller_sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);
  import axi_overrange_poller_pkg::*;

  logic [CNT_WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? CNT_WIDTH'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/axi_overrange_poller.sv
// AXI4-Lite read initiator that periodically polls the overrange status
// register and accumulates its bits into saturating counts and sticky flags.
module axi_overrange_poller #(
  parameter int unsigned               AXI_DATA_WIDTH = 32,
  parameter int unsigned               AXI_ADDR_WIDTH = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0] POLL_ADDR      = '0,
  parameter int unsigned               POLL_PERIOD    = 1024,
  parameter int unsigned               TIMEOUT        = 256,
  parameter int unsigned               CNT_WIDTH      = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic                      enable,
  input  logic                      clear,
  output logic [1:0]                ovr_status,
  output logic [1:0]                ovr_sticky,
  output logic [CNT_WIDTH-1:0]      ovr1_count,
  output logic [CNT_WIDTH-1:0]      ovr2_count,
  output logic                      resp_err,
  output logic                      timeout_err,
  output logic                      poll_done
);
  import axi_overrange_poller_pkg::*;

  localparam int unsigned PER_W = $clog2(POLL_PERIOD + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_e                    state_d, state_q;
  logic [PER_W-1:0]          per_d, per_q;
  logic [TMO_W-1:0]          tmo_d, tmo_q;
  logic                      arvalid_d, arvalid_q;
  logic                      rready_d, rready_q;
  logic                      poll_done_d, poll_done_q;
  logic [OVR_NUM-1:0]        status_d, status_q;
  logic [OVR_NUM-1:0]        sticky_d, sticky_q;
  logic                      resp_err_d, resp_err_q;
  logic                      tmo_err_d, tmo_err_q;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q;
  logic                      ok_hs;
  logic                      unused_rdata;

  // Timeout counter stops at TIMEOUT so the flag is raised exactly once per phase.
  always_comb begin
    state_d     = state_q;
    per_d       = per_q;
    tmo_d       = tmo_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    poll_done_d = 1'b0;
    status_d    = status_q;
    sticky_d    = clear ? '0 : sticky_q;
    resp_err_d  = clear ? 1'b0 : resp_err_q;
    tmo_err_d   = clear ? 1'b0 : tmo_err_q;
    ok_hs       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!enable) begin
          per_d = '0;
        end else if (per_q == PER_W'(POLL_PERIOD - 1)) begin
          per_d     = '0;
          tmo_d     = '0;
          arvalid_d = 1'b1;
          state_d   = ST_ADDR;
        end else begin
          per_d = per_q + PER_W'(1);
        end
      end
      ST_ADDR: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          tmo_d     = '0;
          state_d   = ST_DATA;
        end else begin
          if (tmo_q != TMO_W'(TIMEOUT)) tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_W'(TIMEOUT - 1)) tmo_err_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (rready_q && m_axi_rvalid) begin
          rready_d    = 1'b0;
          poll_done_d = 1'b1;
          state_d     = ST_IDLE;
          if (axi_resp_e'(m_axi_rresp) == RESP_OKAY) begin
            ok_hs    = 1'b1;
            status_d = m_axi_rdata[OVR_NUM-1:0];
            sticky_d = sticky_d | m_axi_rdata[OVR_NUM-1:0];
          end else begin
            resp_err_d = 1'b1;
          end
        end else begin
          if (tmo_q != TMO_W'(TIMEOUT)) tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_W'(TIMEOUT - 1)) tmo_err_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      per_q       <= '0;
      tmo_q       <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      poll_done_q <= 1'b0;
      status_q    <= '0;
      sticky_q    <= '0;
      resp_err_q  <= 1'b0;
      tmo_err_q   <= 1'b0;
      araddr_q    <= POLL_ADDR;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      tmo_q       <= tmo_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      poll_done_q <= poll_done_d;
      status_q    <= status_d;
      sticky_q    <= sticky_d;
      resp_err_q  <= resp_err_d;
      tmo_err_q   <= tmo_err_d;
      araddr_q    <= POLL_ADDR;
    end
  end

  axi_overrange_poller_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_adc1 (
    .aclk   (aclk),
    .areset (areset),
    .clr    (clear),
    .inc    (ok_hs & m_axi_rdata[OVR_ADC1_BIT]),
    .count  (ovr1_count)
  );

  axi_overrange_poller_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_adc2 (
    .aclk   (aclk),
    .areset (areset),
    .clr    (clear),
    .inc    (ok_hs & m_axi_rdata[OVR_ADC2_BIT]),
    .count  (ovr2_count)
  );

  // Only the two overrange bits carry meaning.
  assign unused_rdata  = ^m_axi_rdata[AXI_DATA_WIDTH-1:OVR_NUM];

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign ovr_status    = status_q;
  assign ovr_sticky    = sticky_q;
  assign resp_err      = resp_err_q;
  assign timeout_err   = tmo_err_q;
  assign poll_done     = poll_done_q;

endmodule

// File: tb/tb_axi_overrange_poller.sv
// Directed and randomized bench for axi_overrange_poller with an in-bench
// responder and a read-level reference model.
module tb_axi_overrange_poller;

  localparam int unsigned    DW   = 32;
  localparam int unsigned    AW   = 16;
  localparam int unsigned    PER  = 8;
  localparam int unsigned    TMO  = 256;
  localparam int unsigned    CW   = 4;
  localparam logic [AW-1:0]  PADDR = 16'h0040;
  localparam int             CMAX = (1 << CW) - 1;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [AW-1:0] m_axi_araddr;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = 2'b00;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [1:0]    ovr_status;
  logic [1:0]    ovr_sticky;
  logic [CW-1:0] ovr1_count;
  logic [CW-1:0] ovr2_count;
  logic          resp_err;
  logic          timeout_err;
  logic          poll_done;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned last_rise = 0;

  int   exp_c1, exp_c2;
  logic [1:0] exp_status, exp_sticky;
  logic exp_rerr, exp_terr;

  axi_overrange_poller #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .POLL_ADDR      (PADDR),
    .POLL_PERIOD    (PER),
    .TIMEOUT        (TMO),
    .CNT_WIDTH      (CW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .enable        (enable),
    .clear         (clear),
    .ovr_status    (ovr_status),
    .ovr_sticky    (ovr_sticky),
    .ovr1_count    (ovr1_count),
    .ovr2_count    (ovr2_count),
    .resp_err      (resp_err),
    .timeout_err   (timeout_err),
    .poll_done     (poll_done)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    exp_c1 = 0; exp_c2 = 0; exp_status = 2'b00; exp_sticky = 2'b00;
    exp_rerr = 1'b0; exp_terr = 1'b0;
  endfunction

  function automatic void model_clear();
    exp_c1 = 0; exp_c2 = 0; exp_sticky = 2'b00; exp_rerr = 1'b0; exp_terr = 1'b0;
  endfunction

  // One completed read: optional coincident clear, then the read's effect.
  function automatic void model_read(input logic [31:0] data, input logic [1:0] resp, input bit clr);
    if (clr) model_clear();
    if (resp == 2'b00) begin
      exp_status = data[1:0];
      exp_sticky = exp_sticky | data[1:0];
      exp_c1 = (exp_c1 + int'(data[0]) > CMAX) ? CMAX : exp_c1 + int'(data[0]);
      exp_c2 = (exp_c2 + int'(data[1]) > CMAX) ? CMAX : exp_c2 + int'(data[1]);
    end else begin
      exp_rerr = 1'b1;
    end
  endfunction

  task automatic check_all(input string tag);
    chk($sformatf("%s_status", tag), 32'(ovr_status), 32'(exp_status));
    chk($sformatf("%s_sticky", tag), 32'(ovr_sticky), 32'(exp_sticky));
    chk($sformatf("%s_cnt1", tag), 32'(ovr1_count), 32'(exp_c1));
    chk($sformatf("%s_cnt2", tag), 32'(ovr2_count), 32'(exp_c2));
    chk($sformatf("%s_resp_err", tag), 32'(resp_err), 32'(exp_rerr));
    chk($sformatf("%s_timeout_err", tag), 32'(timeout_err), 32'(exp_terr));
  endtask

  task automatic wait_arvalid(input string tag);
    int n;
    n = 0;
    while (m_axi_arvalid !== 1'b1 && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 1000) chk($sformatf("%s_arvalid_wait", tag), 32'(m_axi_arvalid), 32'd1);
    last_rise = cyc;
  endtask

  // Entered on a negedge with arvalid high; leaves on the cycle after the data handshake.
  task automatic complete_read(input int aw, input int rw, input logic [31:0] data,
                               input logic [1:0] resp, input bit clr_hs, input bit drop_en,
                               input string tag);
    repeat (aw) @(negedge aclk);
    chk($sformatf("%s_arvalid_held", tag), 32'(m_axi_arvalid), 32'd1);
    m_axi_arready = 1'b1;
    @(negedge aclk);
    m_axi_arready = 1'b0;
    if (drop_en) enable = 1'b0;
    repeat (rw) @(negedge aclk);
    chk($sformatf("%s_rready", tag), 32'(m_axi_rready), 32'd1);
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = data;
    m_axi_rresp  = resp;
    if (clr_hs) clear = 1'b1;
    @(negedge aclk);
    m_axi_rvalid = 1'b0;
    m_axi_rdata  = '0;
    m_axi_rresp  = 2'b00;
    clear        = 1'b0;
    model_read(data, resp, clr_hs);
    chk($sformatf("%s_poll_done", tag), 32'(poll_done), 32'd1);
    chk($sformatf("%s_idle_arvalid", tag), 32'(m_axi_arvalid), 32'd0);
    check_all(tag);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge aclk);
    clear = 1'b0;
    model_clear();
  endtask

  initial begin
    int unsigned t0;
    int unsigned prev;
    int rises;
    logic [31:0] d;
    logic [1:0]  r;

    // Reset values
    model_reset();
    enable = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    chk("rst_rready", 32'(m_axi_rready), 32'd0);
    chk("rst_araddr", 32'(m_axi_araddr), 32'(PADDR));
    chk("rst_poll_done", 32'(poll_done), 32'd0);
    check_all("rst");

    // First arvalid POLL_PERIOD cycles after reset release, then three zero-wait 0x3 reads
    areset = 1'b0;
    t0 = cyc;
    wait_arvalid("first");
    chk("first_latency", last_rise - t0, PER);
    chk("araddr", 32'(m_axi_araddr), 32'(PADDR));
    complete_read(0, 0, 32'h3, 2'b00, 1'b0, 1'b0, "poll1");
    for (int i = 2; i <= 3; i++) begin
      prev = last_rise;
      wait_arvalid("poll");
      chk($sformatf("interval%0d", i), last_rise - prev, PER + 2);
      complete_read(0, 0, 32'h3, 2'b00, 1'b0, 1'b0, $sformatf("poll%0d", i));
    end

    // Address phase stalled 300 cycles: timeout flag after 256, read still completes
    wait_arvalid("tmo");
    repeat (TMO - 1) @(negedge aclk);
    chk("tmo_before", 32'(timeout_err), 32'd0);
    chk("tmo_arvalid", 32'(m_axi_arvalid), 32'd1);
    @(negedge aclk);
    chk("tmo_at", 32'(timeout_err), 32'd1);
    exp_terr = 1'b1;
    complete_read(300 - TMO, 0, 32'h2, 2'b00, 1'b0, 1'b0, "tmo_read");

    // Clear in idle leaves ovr_status alone
    pulse_clear();
    check_all("clear_idle");

    // Error response: only resp_err moves
    wait_arvalid("slverr");
    complete_read(1, 2, 32'h1, 2'b10, 1'b0, 1'b0, "slverr");

    // Saturation at 4 bits
    pulse_clear();
    for (int i = 0; i < 20; i++) begin
      wait_arvalid("sat");
      complete_read(0, 0, 32'h1, 2'b00, 1'b0, 1'b0, $sformatf("sat%0d", i));
    end
    chk("sat_final_cnt1", 32'(ovr1_count), 32'd15);

    // Clear coinciding with a counting read
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      wait_arvalid("pre");
      complete_read(0, 0, 32'h2, 2'b00, 1'b0, 1'b0, $sformatf("pre%0d", i));
    end
    wait_arvalid("clr_hs");
    complete_read(0, 0, 32'h2, 2'b00, 1'b1, 1'b0, "clr_hs");
    chk("clr_hs_cnt2_is_1", 32'(ovr2_count), 32'd1);

    // Clear coinciding with an error response
    wait_arvalid("clr_err");
    complete_read(0, 1, 32'h3, 2'b11, 1'b1, 1'b0, "clr_err");

    // Randomized reads
    for (int i = 0; i < 30; i++) begin
      d = $urandom;
      r = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      wait_arvalid("rnd");
      complete_read(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d, r,
                    ($urandom_range(0, 7) == 0), 1'b0, $sformatf("rnd%0d", i));
    end

    // enable dropped during the data phase
    wait_arvalid("drop");
    complete_read(0, 3, 32'h1, 2'b00, 1'b0, 1'b1, "drop");
    rises = 0;
    repeat (40) begin
      @(negedge aclk);
      if (m_axi_arvalid === 1'b1) rises++;
    end
    chk("drop_no_arvalid", 32'(rises), 32'd0);
    enable = 1'b1;
    t0 = cyc;
    wait_arvalid("reenable");
    chk("reenable_latency", last_rise - t0, PER);
    complete_read(0, 0, 32'h3, 2'b00, 1'b0, 1'b0, "reenable");

    // areset while waiting in the address phase
    wait_arvalid("rst_addr");
    repeat (2) @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    model_reset();
    chk("rst_addr_arvalid", 32'(m_axi_arvalid), 32'd0);
    chk("rst_addr_rready", 32'(m_axi_rready), 32'd0);
    chk("rst_addr_araddr", 32'(m_axi_araddr), 32'(PADDR));
    chk("rst_addr_poll_done", 32'(poll_done), 32'd0);
    check_all("rst_addr");
    areset = 1'b0;
    t0 = cyc;
    wait_arvalid("after_rst");
    chk("after_rst_latency", last_rise - t0, PER);
    complete_read(0, 0, 32'h1, 2'b00, 1'b0, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_overrange_poller.md
# axi_overrange_poller

AXI4-Lite read initiator that periodically polls the ADC overrange status register and turns its read-to-clear latched bits into saturating per-ADC event counts and sticky flags. Sits between the overrange status responder on the processor-side AXI4-Lite interconnect and the fabric logic that reports ADC health to the protocol layer. It only ever issues single-beat reads of one fixed address; it never writes.

## Interface
Parameters:
- AXI_DATA_WIDTH, 32, read data width
- AXI_ADDR_WIDTH, 16, address width
- POLL_ADDR, 0, address of the status register
- POLL_PERIOD, 1024, idle cycles between the end of one read and the start of the next (minimum 1)
- TIMEOUT, 256, cycles an address or data phase may wait before the timeout flag is set
- CNT_WIDTH, 16, width of each event counter

Ports:
- aclk  in  1  clock; all logic on the rising edge
- areset  in  1  reset; synchronous, active-high
- m_axi_araddr  out  AXI_ADDR_WIDTH  read address, constant POLL_ADDR
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  AXI_DATA_WIDTH  read data; bit 0 = ADC1 overrange, bit 1 = ADC2 overrange
- m_axi_rresp  in  2  read response
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready
- enable  in  1  polling enabled
- clear  in  1  one-cycle pulse: zero counters and sticky flags
- ovr_status  out  2  rdata[1:0] of the last OKAY read
- ovr_sticky  out  2  per-ADC flag, set by any OKAY read with that bit high
- ovr1_count  out  CNT_WIDTH  OKAY reads with bit 0 high, saturating
- ovr2_count  out  CNT_WIDTH  OKAY reads with bit 1 high, saturating
- resp_err  out  1  sticky: a read completed with rresp != OKAY
- timeout_err  out  1  sticky: a phase exceeded TIMEOUT cycles
- poll_done  out  1  one-cycle pulse per completed read

## Operation
- All outputs registered. Reset values: arvalid 0, rready 0, araddr POLL_ADDR, all status, counts, flags and poll_done 0; state IDLE, period and timeout counters 0.
- States: IDLE, ADDR, DATA.
- IDLE: period counter increments while enable=1, held at 0 while enable=0. At POLL_PERIOD-1 → ADDR, counter cleared.
- ADDR: arvalid=1. On arvalid&arready → DATA, arvalid=0.
- DATA: rready=1. On rvalid&rready → IDLE, rready=0, poll_done pulses.
- On data handshake with rresp=00: ovr_status <= rdata[1:0]; sticky bits OR-in; each counter increments by 1 if its bit is set, holding at all-ones.
- On data handshake with rresp≠00: resp_err set; ovr_status, sticky bits and counters unchanged.
- Timeout: counter runs in ADDR and DATA, clears on entry to each. On reaching TIMEOUT, timeout_err is set and the phase continues; arvalid/rready are never withdrawn before the handshake. Only areset escapes a hung slave.
- enable falling mid-transaction: the transaction completes normally, then the block stays in IDLE.
- clear: zeroes the counters, ovr_sticky, resp_err and timeout_err. It does not affect ovr_status or the FSM.
  - If clear coincides with a counting read, the result is that read alone: count = 1 where the bit is set, sticky = the read's bits.
  - If clear coincides with an error event, the error flag ends set.
- areset mid-transaction: immediate return to reset values. The slave must be reset in the same domain.

## Timing
- Zero-wait slave:
  - cycle 0: arvalid rises.
  - cycle 0 edge: address handshake.
  - cycle 1: rready=1; slave presents rvalid.
  - cycle 1 edge: data handshake.
  - cycle 2: counts, ovr_status and poll_done valid.
- Poll interval at zero wait: POLL_PERIOD + 2 cycles, arvalid rise to arvalid rise.
- First arvalid: POLL_PERIOD cycles after reset release with enable high, or after enable rises.

## Structure
- Shared package: AXI response codes (OKAY, SLVERR and the other encodings), state encoding, overrange bit indices.
- Natural sub-module: sat_counter (CNT_WIDTH, synchronous clear, increment, clear-with-increment loads 1), instantiated once per ADC.

## Test plan
- Zero-wait responder model, POLL_PERIOD=8, rdata=0x3 each read → after 3 polls: ovr1_count=3, ovr2_count=3, ovr_sticky=11. arvalid rises are 10 cycles apart.
- Slave holds arready low 300 cycles with TIMEOUT=256 → timeout_err set at cycle 256. arvalid stays high throughout, and the read then completes with poll_done.
- rresp=10 with rdata=0x1 → resp_err=1; ovr1_count, ovr_status and ovr_sticky unchanged.
- CNT_WIDTH=4, 20 reads of 0x1 → ovr1_count=15, ovr2_count=0.
- clear asserted on the data-handshake cycle of a 0x2 read with ovr2_count=5 → ovr2_count=1, ovr1_count=0, ovr_sticky=10.
- enable dropped while in DATA → read completes, poll_done pulses, no further arvalid. areset asserted while in ADDR → arvalid=0 next cycle and all outputs at reset values.
